stonyman_capture_ctrl: RTL and testbench

- Frame-capture sequencer behind the Stonyman APB3 register block.
- On a START_CAPTURE strobe, walks the Stonyman sensor's row/column registers via RESP/INCP/RESV/INCV pulses.
- Per pixel: waits for analog settle, triggers the external 8-bit ADC, pushes each sample into the pixel FIFO in row-major order.
- Reports BUSY for the whole frame; that FIFO is the one the APB side drains.

---
 rtl/stonyman_pkg.sv | 66 ++++++
 rtl/stonyman_pulse_gen.sv | 44 ++++
 rtl/stonyman_capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_stonyman_capture_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stonyman_pkg.sv
// rtl/stonyman_pkg.sv - shared types, defaults and pulse-sequence tables for the Stonyman capture sequencer
package stonyman_pkg;

    localparam int DEF_ROWS          = 112;
    localparam int DEF_COLS          = 112;
    localparam int DEF_PULSE_CYCLES  = 2;
    localparam int DEF_SETTLE_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME_INIT,
        ST_ROW_INIT,
        ST_SETTLE,
        ST_CONVERT,
        ST_WRITE,
        ST_COL_NEXT,
        ST_ROW_END
    } state_t;

    typedef enum logic [2:0] {
        PL_NONE,
        PL_RESP,
        PL_INCP,
        PL_RESV,
        PL_INCV
    } pulse_sel_t;

    // FRAME_INIT = SELROW+RESV, ROW_INIT = SELCOL+RESV, ROW_END = SELROW+INCV, COL_NEXT = INCV
    function automatic pulse_sel_t seq_sel(input state_t st, input logic [1:0] step);
        pulse_sel_t sel;
        sel = PL_NONE;
        case (st)
            ST_FRAME_INIT, ST_ROW_END: begin
                case (step)
                    2'd0:       sel = PL_RESP;
                    2'd1, 2'd2: sel = PL_INCP;
                    default: begin
                        if (st == ST_FRAME_INIT) sel = PL_RESV;
                        else                     sel = PL_INCV;
                    end
                endcase
            end
            ST_ROW_INIT: begin
                case (step)
                    2'd0:    sel = PL_RESP;
                    2'd1:    sel = PL_INCP;
                    default: sel = PL_RESV;
                endcase
            end
            ST_COL_NEXT: sel = PL_INCV;
            default:     sel = PL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] seq_last(input state_t st);
        logic [1:0] last;
        case (st)
            ST_FRAME_INIT, ST_ROW_END: last = 2'd3;
            ST_ROW_INIT:               last = 2'd2;
            default:                   last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/stonyman_pulse_gen.sv
// rtl/stonyman_pulse_gen.sv - drives one sensor control line high then all low, PULSE_CYCLES each
module stonyman_pulse_gen
    import stonyman_pkg::*;
#(
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic       i_req,
    input  pulse_sel_t i_sel,
    output logic       o_resp,
    output logic       o_incp,
    output logic       o_resv,
    output logic       o_incv,
    output logic       o_done
);

    localparam int CNT_W = $clog2(2 * PULSE_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             w_high;
    logic             w_last;

    // Holding i_req across done chains the next pulse with no idle cycle
    assign w_high = i_req && (r_cnt < CNT_W'(PULSE_CYCLES));
    assign w_last = (r_cnt == CNT_W'(2 * PULSE_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_cnt <= '0;
        end else if (!i_req || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_resp = w_high && (i_sel == PL_RESP);
    assign o_incp = w_high && (i_sel == PL_INCP);
    assign o_resv = w_high && (i_sel == PL_RESV);
    assign o_incv = w_high && (i_sel == PL_INCV);
    assign o_done = i_req && w_last;

endmodule

// File: rtl/stonyman_capture_ctrl.sv
// rtl/stonyman_capture_ctrl.sv - frame capture sequencer: sensor walk, ADC handshake, pixel FIFO writes
module stonyman_capture_ctrl
    import stonyman_pkg::*;
#(
    parameter int ROWS          = DEF_ROWS,
    parameter int COLS          = DEF_COLS,
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic       START_CAPTURE,
    output logic       BUSY,
    output logic       RESP,
    output logic       INCP,
    output logic       RESV,
    output logic       INCV,
    output logic       ADC_START,
    input  logic       ADC_DONE,
    input  logic [7:0] ADC_DATA,
    output logic       FIFO_WE,
    output logic [7:0] FIFO_DATA,
    input  logic       FULL
);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_step;
    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic [15:0] r_wait;
    logic        r_adc_issued;
    logic [7:0]  r_pixel;

    logic        w_pulse_req;
    pulse_sel_t  w_pulse_sel;
    logic        w_pulse_done;
    logic        w_seq_end;
    logic        w_last_row;
    logic        w_last_col;
    logic        w_settled;
    logic        w_write;

    assign w_last_row = (r_row == 8'(ROWS - 1));
    assign w_last_col = (r_col == 8'(COLS - 1));
    assign w_seq_end  = w_pulse_done && (r_step == seq_last(r_state));
    assign w_settled  = (r_wait == 16'(SETTLE_CYCLES - 1));
    assign w_write    = (r_state == ST_WRITE) && !FULL;

    stonyman_pulse_gen #(
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_pulse_gen (
        .PCLK   (PCLK),
        .PRESERN(PRESERN),
        .i_req  (w_pulse_req),
        .i_sel  (w_pulse_sel),
        .o_resp (RESP),
        .o_incp (INCP),
        .o_resv (RESV),
        .o_incv (INCV),
        .o_done (w_pulse_done)
    );

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pulse_req = 1'b0;
        w_pulse_sel = PL_NONE;
        case (r_state)
            ST_IDLE: begin
                if (!START_CAPTURE) w_next = ST_FRAME_INIT;
            end
            ST_FRAME_INIT: begin
                w_pulse_req = 1'b1;
                w_pulse_sel = seq_sel(r_state, r_step);
                if (w_seq_end) w_next = ST_ROW_INIT;
            end
            ST_ROW_INIT: begin
                w_pulse_req = 1'b1;
                w_pulse_sel = seq_sel(r_state, r_step);
                if (w_seq_end) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settled) w_next = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (ADC_DONE) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (!FULL) w_next = w_last_col ? ST_ROW_END : ST_COL_NEXT;
            end
            ST_COL_NEXT: begin
                w_pulse_req = 1'b1;
                w_pulse_sel = seq_sel(r_state, r_step);
                if (w_seq_end) w_next = ST_SETTLE;
            end
            ST_ROW_END: begin
                if (w_last_row) begin
                    w_next = ST_IDLE;
                end else begin
                    w_pulse_req = 1'b1;
                    w_pulse_sel = seq_sel(r_state, r_step);
                    if (w_seq_end) w_next = ST_ROW_INIT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_step       <= 2'd0;
            r_row        <= 8'd0;
            r_col        <= 8'd0;
            r_wait       <= 16'd0;
            r_adc_issued <= 1'b0;
            r_pixel      <= 8'd0;
        end else begin
            if (w_seq_end)         r_step <= 2'd0;
            else if (w_pulse_done) r_step <= r_step + 2'd1;

            if (w_seq_end && (r_state == ST_FRAME_INIT)) r_row <= 8'd0;
            else if (w_seq_end && (r_state == ST_ROW_END)) r_row <= r_row + 8'd1;

            if (w_seq_end && (r_state == ST_ROW_INIT)) r_col <= 8'd0;
            else if (w_seq_end && (r_state == ST_COL_NEXT)) r_col <= r_col + 8'd1;

            r_wait <= (r_state == ST_SETTLE) ? r_wait + 16'd1 : 16'd0;

            // ADC_START only on the first CONVERT cycle, however long the ADC takes
            r_adc_issued <= (r_state == ST_CONVERT) && (w_next == ST_CONVERT);

            if ((r_state == ST_CONVERT) && ADC_DONE) r_pixel <= ADC_DATA;
        end
    end

    assign BUSY      = (r_state != ST_IDLE);
    assign ADC_START = (r_state == ST_CONVERT) && !r_adc_issued;
    assign FIFO_WE   = !w_write;
    assign FIFO_DATA = r_pixel;

endmodule

// File: tb/tb_stonyman_capture_ctrl.sv
// tb/tb_stonyman_capture_ctrl.sv - randomized self-checking bench for stonyman_capture_ctrl
module tb_stonyman_capture_ctrl;

    localparam int ROWS    = 2;
    localparam int COLS    = 3;
    localparam int PC      = 2;
    localparam int SC      = 16;
    localparam int NPIX    = ROWS * COLS;
    localparam int LATENCY = 1 + 2 * PC * (3 + 1 + 2 + 1) + SC;
    localparam int BOUND   = 5000;

    logic       PCLK = 1'b0;
    logic       PRESERN;
    logic       START_CAPTURE;
    logic       BUSY;
    logic       RESP;
    logic       INCP;
    logic       RESV;
    logic       INCV;
    logic       ADC_START;
    logic       ADC_DONE;
    logic [7:0] ADC_DATA;
    logic       FIFO_WE;
    logic [7:0] FIFO_DATA;
    logic       FULL;

    stonyman_capture_ctrl #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .PULSE_CYCLES (PC),
        .SETTLE_CYCLES(SC)
    ) dut (
        .PCLK         (PCLK),
        .PRESERN      (PRESERN),
        .START_CAPTURE(START_CAPTURE),
        .BUSY         (BUSY),
        .RESP         (RESP),
        .INCP         (INCP),
        .RESV         (RESV),
        .INCV         (INCV),
        .ADC_START    (ADC_START),
        .ADC_DONE     (ADC_DONE),
        .ADC_DATA     (ADC_DATA),
        .FIFO_WE      (FIFO_WE),
        .FIFO_DATA    (FIFO_DATA),
        .FULL         (FULL)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] base;
    int         conv_k;
    int         adc_delay;
    int         stall_idx;
    int         last_wr_cyc;
    logic [7:0] got_q[$];
    int         cnt_pulse[4];
    int         sreg[8];
    int         ptr;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model: answers each convert request after a chosen delay, optionally stalling the FIFO
    initial begin : adc_model
        ADC_DONE = 1'b0;
        ADC_DATA = 8'd0;
        FULL     = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESERN === 1'b1 && ADC_START === 1'b1) begin
                int d;
                logic [7:0] e;
                d = (adc_delay < 0) ? int'($urandom_range(0, 4)) : adc_delay;
                repeat (d) @(negedge PCLK);
                e        = 8'(base + 8'(conv_k));
                ADC_DATA = e;
                ADC_DONE = 1'b1;
                if (conv_k == stall_idx) FULL = 1'b1;
                @(negedge PCLK);
                ADC_DONE = 1'b0;
                ADC_DATA = 8'($urandom);
                if (conv_k == stall_idx) begin
                    for (int i = 0; i < 20; i++) begin
                        check("stall_we_high", {31'd0, FIFO_WE}, 32'd1);
                        check("stall_data_held", {24'd0, FIFO_DATA}, {24'd0, e});
                        if (i < 19) @(negedge PCLK);
                    end
                    FULL = 1'b0;
                end
                conv_k++;
            end
        end
    end

    // Line monitor plus a sensor model: pointer register and per-register value counters
    initial begin : line_monitor
        logic [3:0] lines;
        logic [3:0] prev;
        int         hi_run[4];
        int         lo_run;
        prev   = 4'd0;
        lo_run = 1000;
        for (int j = 0; j < 4; j++) hi_run[j] = 0;
        forever begin
            @(negedge PCLK);
            lines = {INCV, RESV, INCP, RESP};
            if (PRESERN !== 1'b1) begin
                prev   = 4'd0;
                lo_run = 1000;
                for (int j = 0; j < 4; j++) hi_run[j] = 0;
            end else begin
                if (lines != 4'd0) check("one_line_high", {31'd0, $countones(lines) <= 1}, 32'd1);
                for (int j = 0; j < 4; j++) begin
                    if (lines[j] && !prev[j]) begin
                        check("pulse_low_gap", {31'd0, lo_run >= PC}, 32'd1);
                        cnt_pulse[j]++;
                        case (j)
                            0: ptr = 0;
                            1: ptr = ptr + 1;
                            2: sreg[ptr & 7] = 0;
                            default: sreg[ptr & 7] = sreg[ptr & 7] + 1;
                        endcase
                    end
                    if (lines[j]) begin
                        hi_run[j]++;
                    end else if (prev[j]) begin
                        check("pulse_high_width", hi_run[j], PC);
                        hi_run[j] = 0;
                    end
                end
                lo_run = (lines == 4'd0) ? lo_run + 1 : 0;
                prev   = lines;
                if (ADC_START === 1'b1) begin
                    check("sensor_row_at_convert", sreg[2], conv_k / COLS);
                    check("sensor_col_at_convert", sreg[1], conv_k % COLS);
                end
                if (FIFO_WE === 1'b0) begin
                    check("write_while_full", {31'd0, FULL}, 32'd0);
                    got_q.push_back(FIFO_DATA);
                    last_wr_cyc = cyc;
                end
            end
        end
    end

    task automatic prep();
        got_q.delete();
        for (int j = 0; j < 4; j++) cnt_pulse[j] = 0;
        conv_k = 0;
        base   = 8'($urandom);
    endtask

    task automatic strobe();
        START_CAPTURE = 1'b0;
        @(negedge PCLK);
        START_CAPTURE = 1'b1;
    endtask

    task automatic run_frame(input bit lat, input bit restrobe);
        int n;
        bit seen;
        prep();
        check("busy_idle_before", {31'd0, BUSY}, 32'd0);
        strobe();
        check("busy_after_strobe", {31'd0, BUSY}, 32'd1);
        if (lat) begin
            n    = 1;
            seen = 1'b0;
            while (!seen && n < 200) begin
                if (ADC_START === 1'b1) seen = 1'b1;
                else begin
                    @(negedge PCLK);
                    n++;
                end
            end
            check("start_to_adc_latency", n, LATENCY);
        end
        if (restrobe) begin
            repeat (100) @(negedge PCLK);
            check("busy_before_restrobe", {31'd0, BUSY}, 32'd1);
            strobe();
        end
        n = 0;
        while (BUSY !== 1'b0 && n < BOUND) begin
            @(negedge PCLK);
            n++;
        end
        check("frame_completes", {31'd0, n < BOUND}, 32'd1);
        check("busy_fall_after_last_write", cyc - last_wr_cyc, 2);
        check("write_count", got_q.size(), NPIX);
        for (int i = 0; i < got_q.size() && i < NPIX; i++)
            check("pixel_data_order", {24'd0, got_q[i]}, {24'd0, 8'(base + 8'(i))});
        check("resp_pulses", cnt_pulse[0], 1 + ROWS + (ROWS - 1));
        check("incp_pulses", cnt_pulse[1], 2 + ROWS + 2 * (ROWS - 1));
        check("resv_pulses", cnt_pulse[2], 1 + ROWS);
        check("incv_pulses", cnt_pulse[3], ROWS * (COLS - 1) + (ROWS - 1));
        check("sensor_row_final", sreg[2], ROWS - 1);
        check("sensor_col_final", sreg[1], COLS - 1);
        repeat (20) @(negedge PCLK);
        check("no_writes_after_frame", got_q.size(), NPIX);
    endtask

    initial begin : main
        int n;
        PRESERN       = 1'b0;
        START_CAPTURE = 1'b1;
        adc_delay     = -1;
        stall_idx     = -1;
        conv_k        = 0;
        base          = 8'd0;
        ptr           = 0;
        last_wr_cyc   = 0;
        for (int j = 0; j < 8; j++) sreg[j] = 0;
        #1;
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_lines", {28'd0, INCV, RESV, INCP, RESP}, 32'd0);
        check("reset_adc_start", {31'd0, ADC_START}, 32'd0);
        check("reset_fifo_we", {31'd0, FIFO_WE}, 32'd1);
        check("reset_fifo_data", {24'd0, FIFO_DATA}, 32'd0);
        repeat (3) @(negedge PCLK);
        PRESERN = 1'b1;
        @(negedge PCLK);

        run_frame(1'b1, 1'b0);

        stall_idx = 2;
        run_frame(1'b0, 1'b0);
        stall_idx = -1;

        run_frame(1'b0, 1'b1);

        prep();
        adc_delay = 3;
        strobe();
        n = 0;
        while (!(ADC_START === 1'b1 && conv_k == 3) && n < BOUND) begin
            @(negedge PCLK);
            n++;
        end
        check("reached_pixel3_convert", {31'd0, n < BOUND}, 32'd1);
        #1 PRESERN = 1'b0;
        #1;
        check("midframe_reset_busy", {31'd0, BUSY}, 32'd0);
        check("midframe_reset_lines", {28'd0, INCV, RESV, INCP, RESP}, 32'd0);
        check("midframe_reset_adc_start", {31'd0, ADC_START}, 32'd0);
        check("midframe_reset_fifo_we", {31'd0, FIFO_WE}, 32'd1);
        check("midframe_reset_fifo_data", {24'd0, FIFO_DATA}, 32'd0);
        repeat (8) @(negedge PCLK);
        PRESERN = 1'b1;
        check("writes_before_reset", got_q.size(), 3);
        repeat (50) @(negedge PCLK);
        check("busy_after_reset_release", {31'd0, BUSY}, 32'd0);
        check("no_writes_after_reset", got_q.size(), 3);
        adc_delay = -1;
        run_frame(1'b0, 1'b0);

        adc_delay = 0;
        run_frame(1'b0, 1'b0);
        adc_delay = 50;
        run_frame(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
